pal_bar_sequencer: RTL

- Timing controller for the colour-bar test core; runs on the 7 MHz pixel clock.
- Generates the PAL 15.625 kHz line and 50.08 Hz frame schedule (448 clk/line, 312 lines/frame), composite sync and blanking.
- Drives the 3:3:3 RGB outputs from a selectable test pattern.
- Pattern changes arrive through a req/ack handshake and take effect only at a frame boundary, so a frame never tears.

---
 rtl/pal_timing_pkg.sv | 32 +++
 rtl/bar_pattern_gen.sv | 53 +++++
 rtl/pal_bar_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pal_timing_pkg.sv
// Default PAL timing constants, pattern mode encodings and the shared counter type
// for the colour-bar test core.
package pal_timing_pkg;

    localparam int DEF_HTOTAL       = 448;
    localparam int DEF_VTOTAL       = 312;
    localparam int DEF_HACTIVE      = 256;
    localparam int DEF_VACTIVE      = 192;
    localparam int DEF_HBLANK_START = 320;
    localparam int DEF_HBLANK_END   = 416;
    localparam int DEF_HSYNC_START  = 344;
    localparam int DEF_HSYNC_LEN    = 32;
    localparam int DEF_VBLANK_START = 248;
    localparam int DEF_VBLANK_END   = 256;
    localparam int DEF_VSYNC_START  = 248;
    localparam int DEF_VSYNC_LINES  = 4;

    typedef logic [8:0] count_t;

    typedef enum logic [1:0] {
        MODE_VBARS = 2'd0,
        MODE_HBARS = 2'd1,
        MODE_GREY  = 2'd2,
        MODE_BLACK = 2'd3
    } mode_t;

    // Half-open window test lo <= v < hi.
    function automatic logic in_window(count_t v, count_t lo, count_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/bar_pattern_gen.sv
// Combinational test-pattern colour lookup; the parent registers its outputs.
module bar_pattern_gen
    import pal_timing_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [8:0] hc,
    input  logic [8:0] vc,
    input  logic       active,
    output logic [2:0] r,
    output logic [2:0] g,
    output logic [2:0] b
);

    mode_t      mode_e;
    logic [2:0] bar_idx;
    logic       unused_bits;

    // Only the 32-pixel / 32-line bar selector bits drive the pattern.
    assign unused_bits = ^{hc[8], hc[4:0], vc[8], vc[4:0]};

    always_comb begin
        mode_e  = mode_t'(mode);
        bar_idx = 3'd0;
        r       = 3'd0;
        g       = 3'd0;
        b       = 3'd0;
        case (mode_e)
            MODE_VBARS: bar_idx = 3'd7 - hc[7:5];
            MODE_HBARS: bar_idx = 3'd7 - vc[7:5];
            default:    bar_idx = 3'd0;
        endcase
        if (active) begin
            case (mode_e)
                MODE_VBARS, MODE_HBARS: begin
                    g = {3{bar_idx[2]}};
                    r = {3{bar_idx[1]}};
                    b = {3{bar_idx[0]}};
                end
                MODE_GREY: begin
                    r = hc[7:5];
                    g = hc[7:5];
                    b = hc[7:5];
                end
                default: begin
                    r = 3'd0;
                    g = 3'd0;
                    b = 3'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pal_bar_sequencer.sv
// PAL line/frame timing, composite sync, blanking and registered test-pattern RGB,
// with pattern changes deferred to the frame wrap.
module pal_bar_sequencer
    import pal_timing_pkg::*;
#(
    parameter int HTOTAL       = DEF_HTOTAL,
    parameter int VTOTAL       = DEF_VTOTAL,
    parameter int HACTIVE      = DEF_HACTIVE,
    parameter int VACTIVE      = DEF_VACTIVE,
    parameter int HBLANK_START = DEF_HBLANK_START,
    parameter int HBLANK_END   = DEF_HBLANK_END,
    parameter int HSYNC_START  = DEF_HSYNC_START,
    parameter int HSYNC_LEN    = DEF_HSYNC_LEN,
    parameter int VBLANK_START = DEF_VBLANK_START,
    parameter int VBLANK_END   = DEF_VBLANK_END,
    parameter int VSYNC_START  = DEF_VSYNC_START,
    parameter int VSYNC_LINES  = DEF_VSYNC_LINES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       mode_req,
    input  logic [1:0] mode_in,
    output logic       mode_ack,
    output logic [8:0] hc,
    output logic [8:0] vc,
    output logic [2:0] r,
    output logic [2:0] g,
    output logic [2:0] b,
    output logic       csync,
    output logic       hblank,
    output logic       vblank,
    output logic       frame_tick
);

    localparam count_t H_LAST   = count_t'(HTOTAL - 1);
    localparam count_t V_LAST   = count_t'(VTOTAL - 1);
    localparam count_t H_ACT    = count_t'(HACTIVE);
    localparam count_t V_ACT    = count_t'(VACTIVE);
    localparam count_t HB_START = count_t'(HBLANK_START);
    localparam count_t HB_END   = count_t'(HBLANK_END);
    localparam count_t HS_START = count_t'(HSYNC_START);
    localparam count_t HS_END   = count_t'(HSYNC_START + HSYNC_LEN);
    localparam count_t VB_START = count_t'(VBLANK_START);
    localparam count_t VB_END   = count_t'(VBLANK_END);
    localparam count_t VS_START = count_t'(VSYNC_START);
    localparam count_t VS_END   = count_t'(VSYNC_START + VSYNC_LINES);

    count_t     hc_q, hc_d;
    count_t     vc_q, vc_d;
    mode_t      mode_q, mode_d;
    mode_t      pend_val_q, pend_val_d;
    logic       pending_q, pending_d;
    logic [2:0] r_q, r_d;
    logic [2:0] g_q, g_d;
    logic [2:0] b_q, b_d;
    logic       csync_q, csync_d;
    logic       hblank_q, hblank_d;
    logic       vblank_q, vblank_d;
    logic       frame_tick_q, frame_tick_d;
    logic       mode_ack_q, mode_ack_d;

    logic       line_end;
    logic       frame_end;
    logic       hsync_win;
    logic       vsync_line;
    logic       active;
    logic [2:0] pat_r, pat_g, pat_b;

    assign line_end   = (hc_q == H_LAST);
    assign frame_end  = line_end && (vc_q == V_LAST);
    assign hsync_win  = in_window(hc_q, HS_START, HS_END);
    assign vsync_line = in_window(vc_q, VS_START, VS_END);
    assign active     = (hc_q < H_ACT) && (vc_q < V_ACT);

    bar_pattern_gen u_pattern (
        .mode   (mode_q),
        .hc     (hc_q),
        .vc     (vc_q),
        .active (active),
        .r      (pat_r),
        .g      (pat_g),
        .b      (pat_b)
    );

    always_comb begin
        hc_d         = hc_q;
        vc_d         = vc_q;
        mode_d       = mode_q;
        pend_val_d   = pend_val_q;
        pending_d    = pending_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        csync_d      = csync_q;
        hblank_d     = hblank_q;
        vblank_d     = vblank_q;
        frame_tick_d = 1'b0;
        mode_ack_d   = 1'b0;

        if (ce) begin
            hc_d = line_end ? 9'd0 : hc_q + 9'd1;
            if (line_end) begin
                vc_d = frame_end ? 9'd0 : vc_q + 9'd1;
            end

            // Vsync lines use inverted serration: high only inside the hsync window.
            csync_d      = vsync_line ? hsync_win : ~hsync_win;
            hblank_d     = in_window(hc_q, HB_START, HB_END);
            vblank_d     = in_window(vc_q, VB_START, VB_END);
            r_d          = pat_r;
            g_d          = pat_g;
            b_d          = pat_b;
            frame_tick_d = frame_end;

            if (frame_end) begin
                if (mode_req) begin
                    mode_d     = mode_t'(mode_in);
                    pending_d  = 1'b0;
                    mode_ack_d = 1'b1;
                end else if (pending_q) begin
                    mode_d     = pend_val_q;
                    pending_d  = 1'b0;
                    mode_ack_d = 1'b1;
                end
            end else if (mode_req) begin
                pending_d  = 1'b1;
                pend_val_d = mode_t'(mode_in);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q         <= 9'd0;
            vc_q         <= 9'd0;
            mode_q       <= MODE_VBARS;
            pend_val_q   <= MODE_VBARS;
            pending_q    <= 1'b0;
            r_q          <= 3'd0;
            g_q          <= 3'd0;
            b_q          <= 3'd0;
            csync_q      <= 1'b1;
            hblank_q     <= 1'b0;
            vblank_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            mode_ack_q   <= 1'b0;
        end else begin
            hc_q         <= hc_d;
            vc_q         <= vc_d;
            mode_q       <= mode_d;
            pend_val_q   <= pend_val_d;
            pending_q    <= pending_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            csync_q      <= csync_d;
            hblank_q     <= hblank_d;
            vblank_q     <= vblank_d;
            frame_tick_q <= frame_tick_d;
            mode_ack_q   <= mode_ack_d;
        end
    end

    assign hc         = hc_q;
    assign vc         = vc_q;
    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign csync      = csync_q;
    assign hblank     = hblank_q;
    assign vblank     = vblank_q;
    assign frame_tick = frame_tick_q;
    assign mode_ack   = mode_ack_q;

endmodule
